// File: rtl/cacheline_adapter.sv
// cacheline_adapter
// -----------------------------------------------------------------------------
// Serves the cache's 256-bit line requests over a 64-bit burst memory port.
// A line read assembles four incoming beats into a line register. A line
// write-back streams a latched copy of the line out as four beats.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-low reset
//   address_i  line address from the cache
//   read_i     line read request, held until resp_o
//   write_i    line write request, held until resp_o (wins over read_i)
//   line_i     write-back line, sampled on the accept edge
//   line_o     last assembled read line
//   resp_o     one-cycle completion pulse to the cache
//   address_o  line-aligned burst address to memory
//   read_o     burst read request
//   write_o    burst write request
//   burst_o    current write beat
//   burst_i    current read beat
//   resp_i     memory beat acknowledge, one per beat
// -----------------------------------------------------------------------------
module cacheline_adapter #(
  parameter int unsigned s_line   = 256,
  parameter int unsigned s_burst  = 64,
  parameter int unsigned s_offset = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  output logic               resp_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [s_burst-1:0] burst_o,
  input  logic [s_burst-1:0] burst_i,
  input  logic               resp_i
);

  localparam int unsigned Beats = s_line / s_burst;
  localparam int unsigned CntW  = $clog2(Beats);
  localparam logic [31:0] AddrMask = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [s_line-1:0]  rline_q, rline_d;
  logic [s_line-1:0]  wbuf_q, wbuf_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        beat_lsb;
  logic               last_beat;

  // Bit offset of the beat selected by the counter; beat 0 is the low word.
  assign beat_lsb  = 32'(cnt_q) * s_burst;
  assign last_beat = (cnt_q == CntW'(Beats - 1));

  // State, counter and data registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rline_q <= '0;
      wbuf_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rline_q <= rline_d;
      wbuf_q  <= wbuf_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rline_d = rline_q;
    wbuf_d  = wbuf_q;
    addr_d  = addr_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (write_i) begin
          wbuf_d  = line_i;
          addr_d  = address_i & AddrMask;
          state_d = WRITE;
        end else if (read_i) begin
          addr_d  = address_i & AddrMask;
          state_d = READ;
        end
      end

      READ: begin
        read_o = 1'b1;
        if (resp_i) begin
          rline_d[beat_lsb +: s_burst] = burst_i;
          cnt_d = cnt_q + CntW'(1);
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end

      WRITE: begin
        write_o = 1'b1;
        if (resp_i) begin
          cnt_d = cnt_q + CntW'(1);
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign burst_o   = wbuf_q[beat_lsb +: s_burst];
  assign line_o    = rline_q;
  assign address_o = addr_q;

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Adapter between a cache datapath's 256-bit line port and the 64-bit burst physical-memory port. It acts as the memory responder the cache controller talks to. A line read is served by collecting four 64-bit beats into one 256-bit line. A line write-back is served by issuing the stored line as four 64-bit beats. It sits between the cache (or the cache arbiter) and the burst memory model or DRAM controller.

## Interface
Parameters:
- s_line, 256, cacheline width in bits
- s_burst, 64, memory beat width in bits
- s_offset, 5, line offset bits; these are cleared on address_o

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-low; state clears on a rising edge with rst == 0
- address_i  input  32  line address from cache (pmem_address)
- read_i  input  1  line read request; held until resp_o
- write_i  input  1  line write request; held until resp_o
- line_i  input  s_line  write-back data (pmem_wdata)
- line_o  output  s_line  assembled read line (pmem_rdata)
- resp_o  output  1  one-cycle completion pulse to cache
- address_o  output  32  burst address to memory
- read_o  output  1  burst read request
- write_o  output  1  burst write request
- burst_o  output  s_burst  current write beat
- burst_i  input  s_burst  current read beat
- resp_i  input  1  memory beat acknowledge, one per beat

## Operation
- **State machine:** IDLE, READ, WRITE, DONE. There is a 2-bit beat counter `cnt`.
- **IDLE:**
  - If write_i is high, latch line_i into the line buffer and latch address_i into the address register, with bits [s_offset-1:0] forced to 0. Then go to WRITE.
  - Else if read_i is high, latch the address the same way and go to READ.
  - When both are high, write wins.
  - resp_i is ignored in IDLE.
  - cnt is 0 in IDLE.
- **READ:**
  - read_o is 1.
  - On each cycle with resp_i = 1, store burst_i into buffer bits [64·cnt+63 : 64·cnt] and increment cnt.
  - On the beat with cnt == 3, go to DONE with cnt wrapping to 0.
  - Cycles with resp_i = 0 are wait cycles; state, cnt and buffer hold.
- **WRITE:**
  - write_o is 1.
  - burst_o equals buffer bits [64·cnt+63 : 64·cnt].
  - On each resp_i = 1 the current beat is consumed and cnt increments.
  - On the beat with cnt == 3, go to DONE.
- **DONE:**
  - resp_o is 1 for exactly this cycle.
  - line_o is valid.
  - The next state is unconditionally IDLE.
- **Requester rules:**
  - The requester deasserts read_i/write_i in the cycle after resp_o.
  - address_i and line_i need only be valid on the accept edge.
- **Outputs from registers:**
  - address_o is the latched address; it is constant for the whole transaction.
  - line_o is the line buffer. It holds the last completed read line until the next read beat overwrites it.
- **Beat ordering:** beat 0 is line bits [63:0], beat 3 is bits [255:192], both directions.
- **Memory side:**
  - read_o/write_o are never both high.
  - read_o/write_o drop combinationally in DONE and IDLE.

## Timing
- **Reset values:**
  - state = IDLE, cnt = 0, buffer = 0, address register = 0.
  - Outputs: resp_o = 0, read_o = 0, write_o = 0, address_o = 0, line_o = 0, burst_o = 0.
- **Request to memory:** with a request sampled at edge E0, read_o or write_o goes high in the cycle after E0.
- **Completion latency:** if memory acknowledges beats in cycles c0..c3, resp_o is high in cycle c3+1.
  - Minimum latency is request-seen edge to resp_o, 5 cycles: 1 accept + 4 beats.
- **Back-to-back:** the earliest a new request can be accepted is the edge ending the IDLE cycle following DONE.
- **Reset mid-transaction:** rst = 0 at any edge aborts the transaction. Reset values appear in the following cycle, no resp_o is generated, and partial buffer contents are cleared.
- **Stray resp_i:** resp_i in DONE or IDLE has no effect.
- **Extra beats:** resp_i beyond the fourth beat are not counted.

## Test plan
- **Read, no stall:**
  - Stimulus: read_i with address_i = 0x1234_567F; memory acks 4 consecutive beats of 0x0…00, 0x1…11, 0x2…22, 0x3…33.
  - Expect: address_o = 0x1234_5660; resp_o is high for exactly 1 cycle, 5 cycles after accept; line_o = {0x33…, 0x22…, 0x11…, 0x00…}.
- **Write, stalled:**
  - Stimulus: write_i with line_i = {0xDDDD…, 0xCCCC…, 0xBBBB…, 0xAAAA…}; memory waits 2 cycles between acks.
  - Expect: burst_o sequence AAAA, BBBB, CCCC, DDDD, each held until its resp_i; write_o stays high throughout; resp_o is a single pulse.
- **Simultaneous read_i and write_i in IDLE:**
  - Expect: a write burst (write_o = 1, read_o = 0); no read is issued.
- **Reset during READ after 2 beats:**
  - Stimulus: rst = 0.
  - Expect: all outputs 0 the next cycle; line_o = 0; no resp_o. A subsequent read completes normally.
- **Back-to-back read then write:**
  - Expect: the write accepted on the first legal edge after DONE; address_o changes only on accept; no beat overlap.
- **Stray resp_i pulses while IDLE:**
  - Expect: no state change, cnt stays 0, and resp_o stays 0.
